// File: rtl/ks_multiword_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// ks_multiword_add_seq_pkg
//
// Shared definitions for the multi-word Kogge-Stone addition sequencer.
//
// Contents:
//   state_t    - FSM state encoding (ST_IDLE = 0, ST_RUN = 1)
//   clog2_min1 - ceiling log2 that never returns less than 1. The chunk
//                counter uses it so that a counter still exists when there
//                is only a single chunk.
// ---------------------------------------------------------------------------
package ks_multiword_add_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Smallest width able to count 0..value-1, with a floor of one bit.
   function automatic int clog2_min1(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) begin
            result = result + 1;
         end
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ks_multiword_add_seq_kogge_stone.sv
// ---------------------------------------------------------------------------
// kogge_stone_nbit
//
// Purely combinational W-bit Kogge-Stone adder.
//
// Ports:
//   a   [W-1:0] operand A
//   b   [W-1:0] operand B
//   cin         carry into bit 0
//   s   [W:0]   {carry out, W-bit sum}
//
// The prefix tree has ceil(log2(W)) levels. At each level every bit merges
// its (generate, propagate) pair with the pair 'dist' positions below it.
// After the last level, bit i holds the group generate/propagate of the
// span [i:0], so the carry into bit i+1 is g | (p & cin).
// ---------------------------------------------------------------------------
module kogge_stone_nbit #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W:0]   s
);

   localparam int LEVELS = $clog2(W);

   logic [W:0] carry;

   // Build the prefix tree level by level with whole-vector shifts. Bits
   // below the current distance have no partner, so their generate is left
   // as it is and their propagate is masked through unchanged.
   always_comb begin : prefix_tree
      logic [W-1:0] gk;
      logic [W-1:0] pk;
      logic [W-1:0] gn;
      logic [W-1:0] pn;
      gk = a & b;
      pk = a ^ b;
      gn = gk;
      pn = pk;
      for (int l = 0; l < LEVELS; l++) begin
         gn = gk | (pk & (gk << (1 << l)));
         pn = pk & ((pk << (1 << l)) | ~({W{1'b1}} << (1 << l)));
         gk = gn;
         pk = pn;
      end
      carry = {gk | (pk & {W{cin}}), cin};
      s     = {carry[W], (a ^ b) ^ carry[W-1:0]};
   end

endmodule

// File: rtl/ks_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// ks_multiword_add_seq
//
// Adds two W*N-bit operands by reusing a single W-bit Kogge-Stone adder,
// one chunk per clock from the least significant chunk to the most
// significant. The carry out of each chunk is registered and becomes the
// carry in of the next chunk.
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, only looked at while idle
//   a, b   [W*N-1:0] operands, captured on the accepting edge
//   cin    carry into chunk 0, captured on the accepting edge
//   busy   high while an addition is running
//   done   one-cycle pulse; sum/cout are final from this cycle onward
//   sum    [W*N-1:0] result, held until the next accepted start
//   cout   carry out of the top chunk, held with sum
//
// Latency: the start is accepted on edge E0, chunks are added on E1..EN,
// and done is seen in the cycle after EN. Every output is a register, so
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ks_multiword_add_seq
   import ks_multiword_add_seq_pkg::*;
#(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W*N-1:0] a,
   input  logic [W*N-1:0] b,
   input  logic           cin,
   output logic           busy,
   output logic           done,
   output logic [W*N-1:0] sum,
   output logic           cout
);

   localparam int TW = W * N;
   localparam int CW = clog2_min1(N);

   state_t          state;
   state_t          state_n;
   logic [TW-1:0]   a_sh;
   logic [TW-1:0]   b_sh;
   logic [TW-1:0]   sum_r;
   logic [TW-1:0]   sum_shift;
   logic            c_reg;
   logic            cout_r;
   logic            done_r;
   logic [CW-1:0]   cnt;
   logic            last_chunk;
   logic [W:0]      chunk_s;

   // The only adder in the design; it always works on the low chunk of the
   // operand shift registers together with the registered carry.
   kogge_stone_nbit #(
      .W (W)
   ) u_adder (
      .a   (a_sh[W-1:0]),
      .b   (b_sh[W-1:0]),
      .cin (c_reg),
      .s   (chunk_s)
   );

   assign last_chunk = (cnt == CW'(N - 1));

   // The fresh chunk sum enters at the top while the partial result moves
   // down by one chunk. After N steps the first chunk has reached bit 0.
   // Written as shift-and-or so that N = 1 needs no special case.
   assign sum_shift = (sum_r >> W) | (TW'(chunk_s[W-1:0]) << (W * (N - 1)));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic. Leave IDLE on a start and return once the last chunk
   // has been added. Requests that arrive while running are not examined.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_chunk) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Datapath registers. An accepted start captures the operands and clears
   // the previous result. Each running cycle consumes one chunk. On the
   // final chunk the carry becomes cout and done is raised for one cycle.
   // A reset drops any operation in progress, so no done is issued for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_r  <= '0;
         c_reg  <= 1'b0;
         cout_r <= 1'b0;
         done_r <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  c_reg  <= cin;
                  cnt    <= '0;
                  sum_r  <= '0;
                  cout_r <= 1'b0;
               end
            end
            ST_RUN: begin
               sum_r <= sum_shift;
               a_sh  <= a_sh >> W;
               b_sh  <= b_sh >> W;
               c_reg <= chunk_s[W];
               cnt   <= cnt + 1'b1;
               if (last_chunk) begin
                  cout_r <= chunk_s[W];
                  done_r <= 1'b1;
               end
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_ks_multiword_add_seq
//
// Self-checking bench for ks_multiword_add_seq. It instantiates three
// configurations: W=4/N=4 for the directed cases, and W=8/N=3 and W=4/N=1
// for random sweeps. Expected sums come from plain wide addition
// a + b + cin, and expected latency comes from N+1.
// ---------------------------------------------------------------------------
module tb_ks_multiword_add_seq;

   logic        clk;
   logic        rst;

   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;

   logic        start_w;
   logic [23:0] a_w;
   logic [23:0] b_w;
   logic        cin_w;
   logic        busy_w;
   logic        done_w;
   logic [23:0] sum_w;
   logic        cout_w;

   logic        start_n;
   logic [3:0]  a_n;
   logic [3:0]  b_n;
   logic        cin_n;
   logic        busy_n;
   logic        done_n;
   logic [3:0]  sum_n;
   logic        cout_n;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] exp_sum;
      logic        exp_cout;
   } vec_t;

   vec_t vecs [4];

   ks_multiword_add_seq #(.W(4), .N(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   ks_multiword_add_seq #(.W(8), .N(3)) dut_wide (
      .clk   (clk),
      .rst   (rst),
      .start (start_w),
      .a     (a_w),
      .b     (b_w),
      .cin   (cin_w),
      .busy  (busy_w),
      .done  (done_w),
      .sum   (sum_w),
      .cout  (cout_w)
   );

   ks_multiword_add_seq #(.W(4), .N(1)) dut_narrow (
      .clk   (clk),
      .rst   (rst),
      .start (start_n),
      .a     (a_n),
      .b     (b_n),
      .cin   (cin_n),
      .busy  (busy_n),
      .done  (done_n),
      .sum   (sum_n),
      .cout  (cout_n)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Called on the falling edge just after the accepting edge. Counts
   // falling edges until done, with a fixed bound so the bench cannot hang.
   task automatic waitDone(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Present one request to the 16-bit instance for a single cycle, then
   // confirm it was accepted and that the previous result was cleared.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                input logic cv);
      start = 1'b1;
      a     = av;
      b     = bv;
      cin   = cv;
      @(negedge clk);
      start = 1'b0;
      checkOutput("accept_busy", busy, 1);
      checkOutput("accept_done_clear", done, 0);
      checkOutput("accept_sum_clear", sum, 0);
      checkOutput("accept_cout_clear", cout, 0);
   endtask

   // One random addition on the W=8, N=3 instance, checked against a + b + cin.
   task automatic applyStimulusWide(input logic [23:0] av, input logic [23:0] bv,
                                    input logic cv);
      logic [24:0] total;
      int          lat;
      total   = {1'b0, av} + {1'b0, bv} + {24'd0, cv};
      start_w = 1'b1;
      a_w     = av;
      b_w     = bv;
      cin_w   = cv;
      @(negedge clk);
      start_w = 1'b0;
      a_w     = ~av;
      b_w     = ~bv;
      lat = 1;
      while (done_w !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("wide_latency", lat, 4);
      checkOutput("wide_sum", {8'd0, sum_w}, {8'd0, total[23:0]});
      checkOutput("wide_cout", cout_w, total[24]);
      @(negedge clk);
   endtask

   // One random addition on the W=4, N=1 instance.
   task automatic applyStimulusNarrow(input logic [3:0] av, input logic [3:0] bv,
                                      input logic cv);
      logic [4:0] total;
      int         lat;
      total   = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
      start_n = 1'b1;
      a_n     = av;
      b_n     = bv;
      cin_n   = cv;
      @(negedge clk);
      start_n = 1'b0;
      lat = 1;
      while (done_n !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("narrow_latency", lat, 2);
      checkOutput("narrow_sum", {28'd0, sum_n}, {28'd0, total[3:0]});
      checkOutput("narrow_cout", cout_n, total[4]);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int done_seen;

      vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1};

      rst     = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      cin     = 1'b0;
      start_w = 1'b0;
      a_w     = '0;
      b_w     = '0;
      cin_w   = 1'b0;
      start_n = 1'b0;
      a_n     = '0;
      b_n     = '0;
      cin_n   = 1'b0;

      #2 rst = 1'b1;
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_cout", cout, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven directed vectors.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
         waitDone(lat);
         checkOutput($sformatf("vec%0d_latency", i), lat, 5);
         checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
         checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
         checkOutput($sformatf("vec%0d_sum_held", i), sum, vecs[i].exp_sum);
         checkOutput($sformatf("vec%0d_idle", i), busy, 0);
      end

      // A start held high while busy, with different operands, is ignored.
      start = 1'b1;
      a     = 16'hA5A5;
      b     = 16'h5A5B;
      cin   = 1'b0;
      @(negedge clk);
      a     = 16'h1111;
      b     = 16'h2222;
      cin   = 1'b1;
      waitDone(lat);
      checkOutput("hold_latency", lat, 5);
      checkOutput("hold_sum", sum, 16'h0000);
      checkOutput("hold_cout", cout, 1);
      start = 1'b0;
      @(negedge clk);
      checkOutput("hold_done_pulse", done, 0);

      // Asynchronous reset after two chunks: everything clears at once and
      // the discarded operation never reports done.
      applyStimulus(16'h1234, 16'h1111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_sum", sum, 0);
      checkOutput("midrst_cout", cout, 0);
      checkOutput("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      checkOutput("midrst_no_done", done_seen, 0);
      applyStimulus(16'h00FF, 16'h0001, 1'b0);
      waitDone(lat);
      checkOutput("postrst_latency", lat, 5);
      checkOutput("postrst_sum", sum, 16'h0100);
      checkOutput("postrst_cout", cout, 0);
      @(negedge clk);

      // Back-to-back: a new start in the done cycle is accepted at once.
      applyStimulus(16'hFFFF, 16'h0002, 1'b0);
      waitDone(lat);
      checkOutput("b2b_first_sum", sum, 16'h0001);
      checkOutput("b2b_first_cout", cout, 1);
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      waitDone(lat);
      checkOutput("b2b_latency", lat, 5);
      checkOutput("b2b_sum", sum, 16'h0000);
      checkOutput("b2b_cout", cout, 1);
      @(negedge clk);

      // Random sweeps on the other two configurations.
      for (int i = 0; i < 20; i++) begin
         applyStimulusWide(24'($urandom), 24'($urandom), 1'($urandom));
      end
      applyStimulusWide(24'hFFFFFF, 24'h000000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         applyStimulusNarrow(4'($urandom), 4'($urandom), 1'($urandom));
      end
      applyStimulusNarrow(4'hF, 4'hF, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
